// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - ALUFun code constants and datapath width shared by the ALU slice
package alu_unit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_LOGIC = 2'b01,
    GRP_SHIFT = 2'b10,
    GRP_CMP   = 2'b11
  } alu_grp_e;

  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_SUB    = 6'b000001;
  localparam logic [5:0] OP_AND    = 6'b011000;
  localparam logic [5:0] OP_OR     = 6'b011110;
  localparam logic [5:0] OP_XOR    = 6'b010110;
  localparam logic [5:0] OP_NOR    = 6'b010001;
  localparam logic [5:0] OP_PASS_A = 6'b011010;
  localparam logic [5:0] OP_SLL    = 6'b100000;
  localparam logic [5:0] OP_SRL    = 6'b100001;
  localparam logic [5:0] OP_SRA    = 6'b100011;

  // Compare codes live in ALUFun[3:1]; ALUFun[0] is a don't-care for this group.
  localparam logic [2:0] CMP_NEQ = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared adder/subtractor used by arithmetic ops and by EQ/LT compares
module alu_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  logic [W-1:0] b_eff;

  // Subtraction is a + ~b + 1, so carry=0 on a subtract means a borrow occurred.
  assign b_eff          = sub ? ~b : b;
  assign {carry, sum}   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  assign overflow       = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
  assign zero           = (sum == '0);

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - single-stage registered ALU: arithmetic, logic, shift and compare ops
module alu_unit #(
  parameter int WIDTH = alu_unit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic [WIDTH-1:0] Z,
  output logic             Zero,
  output logic             Overflow,
  output logic             Negative
);
  import alu_unit_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] as_sum;
  logic             as_carry, as_ovf, as_zero;
  logic             is_add, is_sub, is_arith;
  logic             lt, cmp_bit;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] z_d;
  logic             zero_d, ovf_d, neg_d;

  assign is_add   = (ALUFun == OP_ADD);
  assign is_sub   = (ALUFun == OP_SUB);
  assign is_arith = is_add | is_sub;
  assign shamt    = A[SHW-1:0];

  // Everything except ADD subtracts, so compares reuse the same subtractor.
  alu_addsub #(.W(WIDTH)) u_addsub (
    .a        (A),
    .b        (B),
    .sub      (!is_add),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf),
    .zero     (as_zero)
  );

  assign lt = Sign ? (as_sum[WIDTH-1] ^ as_ovf) : !as_carry;

  always_comb begin
    cmp_bit = 1'b0;
    case (ALUFun[3:1])
      CMP_EQ:  cmp_bit = as_zero;
      CMP_NEQ: cmp_bit = !as_zero;
      CMP_LT:  cmp_bit = lt;
      CMP_LEZ: cmp_bit = A[WIDTH-1] | (A == '0);
      CMP_LTZ: cmp_bit = A[WIDTH-1];
      CMP_GTZ: cmp_bit = !A[WIDTH-1] && (A != '0);
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    z_d = '0;
    case (alu_grp_e'(ALUFun[5:4]))
      GRP_ARITH: if (is_arith) z_d = as_sum;
      GRP_LOGIC: begin
        case (ALUFun)
          OP_AND:    z_d = A & B;
          OP_OR:     z_d = A | B;
          OP_XOR:    z_d = A ^ B;
          OP_NOR:    z_d = ~(A | B);
          OP_PASS_A: z_d = A;
          default:   z_d = '0;
        endcase
      end
      GRP_SHIFT: begin
        case (ALUFun)
          OP_SLL:  z_d = B << shamt;
          OP_SRL:  z_d = B >> shamt;
          OP_SRA:  z_d = WIDTH'($signed(B) >>> shamt);
          default: z_d = '0;
        endcase
      end
      GRP_CMP:   z_d = {{(WIDTH-1){1'b0}}, cmp_bit};
      default:   z_d = '0;
    endcase
  end

  // Unsigned mode reports carry (ADD) or borrow (SUB) through the overflow flag.
  assign zero_d = is_arith & as_zero;
  assign ovf_d  = is_arith & (Sign ? as_ovf : (is_sub ? !as_carry : as_carry));
  assign neg_d  = is_arith & (Sign ? as_sum[WIDTH-1] : (is_sub & !as_carry));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z        <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Negative <= 1'b0;
    end else begin
      Z        <= z_d;
      Zero     <= zero_d;
      Overflow <= ovf_d;
      Negative <= neg_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit against a behavioural model
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic [31:0] Z;
  logic        Zero, Overflow, Negative;

  int tests;
  int fails;

  alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign),
    .Z(Z), .Zero(Zero), .Overflow(Overflow), .Negative(Negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] f, input logic s);
    logic [31:0] z;
    logic        zf, v, n;
    longint      sr;
    int          sa, sb;
    z = 32'd0; zf = 1'b0; v = 1'b0; n = 1'b0;
    sa = a; sb = b;
    if (f[5:4] == 2'b11) begin
      case (f[3:1])
        3'b001:  z = 32'(a == b);
        3'b000:  z = 32'(a != b);
        3'b010:  z = s ? 32'(sa < sb) : 32'(a < b);
        3'b110:  z = 32'(sa <= 0);
        3'b101:  z = 32'(sa < 0);
        3'b111:  z = 32'(sa > 0);
        default: z = 32'd0;
      endcase
    end else begin
      case (f)
        6'b000000: begin
          z  = a + b;
          sr = longint'(sa) + longint'(sb);
          v  = s ? (sr > 64'sd2147483647 || sr < -64'sd2147483648)
                 : ((longint'(a) + longint'(b)) > 64'hFFFFFFFF);
          n  = s ? z[31] : 1'b0;
          zf = (z == 32'd0);
        end
        6'b000001: begin
          z  = a - b;
          sr = longint'(sa) - longint'(sb);
          v  = s ? (sr > 64'sd2147483647 || sr < -64'sd2147483648) : (a < b);
          n  = s ? z[31] : (a < b);
          zf = (z == 32'd0);
        end
        6'b011000: z = a & b;
        6'b011110: z = a | b;
        6'b010110: z = a ^ b;
        6'b010001: z = ~(a | b);
        6'b011010: z = a;
        6'b100000: z = b << a[4:0];
        6'b100001: z = b >> a[4:0];
        6'b100011: z = $signed(b) >>> a[4:0];
        default:   z = 32'd0;
      endcase
    end
    return {z, zf, v, n};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5];
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'h7FFFFFFF;
    edges[3] = 32'h80000000; edges[4] = 32'hFFFFFFFF;
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return $urandom;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [20];
    ops[0] = 6'b000000; ops[1] = 6'b000001; ops[2] = 6'b011000; ops[3] = 6'b011110;
    ops[4] = 6'b010110; ops[5] = 6'b010001; ops[6] = 6'b011010; ops[7] = 6'b100000;
    ops[8] = 6'b100001; ops[9] = 6'b100011; ops[10] = 6'b110010; ops[11] = 6'b110011;
    ops[12] = 6'b110000; ops[13] = 6'b110100; ops[14] = 6'b111100; ops[15] = 6'b111010;
    ops[16] = 6'b111110; ops[17] = 6'b111001; ops[18] = 6'b000010; ops[19] = 6'b101000;
    if ($urandom_range(7) == 0) return 6'($urandom);
    return ops[$urandom_range(19)];
  endfunction

  task automatic drive_random();
    A = pick_operand(); B = pick_operand(); ALUFun = pick_op(); Sign = 1'($urandom);
  endtask

  task automatic test_reset();
    A = 32'hDEADBEEF; B = 32'h12345678; ALUFun = 6'b000000; Sign = 1'b1;
    #2;
    tests++;
    if ({Z, Zero, Overflow, Negative} !== 35'd0) begin
      fails++;
      $display("FAIL reset_state: got Z=%h flags=%b%b%b, expected all 0", Z, Zero, Overflow, Negative);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] da [20], db [20], ez [20];
    logic [5:0]  df [20];
    logic        ds [20];
    logic [2:0]  ef [20];
    int          n;
    n = 0;
    for (int i = 0; i < 18; i++) begin
      da[i] = 32'h0005B10F; db[i] = 32'h829F81A3; ds[i] = 1'b1; ef[i] = 3'b000;
    end
    df[0]  = 6'b000000; ez[0]  = 32'h82A532B2; ef[0] = 3'b001;
    df[1]  = 6'b000001; ez[1]  = 32'h7D662F6C;
    df[2]  = 6'b011000; ez[2]  = 32'h00058103;
    df[3]  = 6'b011110; ez[3]  = 32'h829FB1AF;
    df[4]  = 6'b010110; ez[4]  = 32'h829A30AC;
    df[5]  = 6'b010001; ez[5]  = 32'h7D604E50;
    df[6]  = 6'b011010; ez[6]  = 32'h0005B10F;
    df[7]  = 6'b100000; ez[7]  = 32'hC0D18000;
    df[8]  = 6'b100001; ez[8]  = 32'h0001053F;
    df[9]  = 6'b100011; ez[9]  = 32'hFFFF053F;
    df[10] = 6'b110010; ez[10] = 32'd0;
    df[11] = 6'b110000; ez[11] = 32'd1;
    df[12] = 6'b110100; ez[12] = 32'd0;
    df[13] = 6'b111100; ez[13] = 32'd0;
    df[14] = 6'b111110; ez[14] = 32'd1;
    df[15] = 6'b111001; ez[15] = 32'd0;
    df[16] = 6'b110100; ez[16] = 32'd1; ds[16] = 1'b0;
    df[17] = 6'b111010; ez[17] = 32'd0;
    da[18] = 32'h7FFFFFFF; db[18] = 32'h1; df[18] = 6'b000000; ds[18] = 1'b1;
    ez[18] = 32'h80000000; ef[18] = 3'b011;
    da[19] = 32'hFFFFFFFF; db[19] = 32'h1; df[19] = 6'b000000; ds[19] = 1'b0;
    ez[19] = 32'h0; ef[19] = 3'b110;
    for (int i = 0; i < 20; i++) begin
      A = da[i]; B = db[i]; ALUFun = df[i]; Sign = ds[i];
      @(posedge clk); #1;
      tests++;
      if ({Z, Zero, Overflow, Negative} !== {ez[i], ef[i]}) begin
        fails++;
        $display("FAIL directed_%0d op=%b: got Z=%h ZVN=%b%b%b, expected Z=%h ZVN=%b",
                 i, df[i], Z, Zero, Overflow, Negative, ez[i], ef[i]);
      end
      n++;
    end
  endtask

  task automatic test_random();
    logic [34:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      exp = model(A, B, ALUFun, Sign);
      @(posedge clk); #1;
      tests++;
      if ({Z, Zero, Overflow, Negative} !== exp) begin
        fails++;
        $display("FAIL random_%0d A=%h B=%h op=%b S=%b: got %h/%b%b%b, expected %h/%b",
                 i, A, B, ALUFun, Sign, Z, Zero, Overflow, Negative, exp[34:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp_q[$];
    logic [34:0] exp;
    drive_random();
    exp_q.push_back(model(A, B, ALUFun, Sign));
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      drive_random();
      exp_q.push_back(model(A, B, ALUFun, Sign));
      #2;
      tests++;
      if ({Z, Zero, Overflow, Negative} !== exp) begin
        fails++;
        $display("FAIL back_to_back_%0d: got %h/%b%b%b, expected %h/%b",
                 i, Z, Zero, Overflow, Negative, exp[34:3], exp[2:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    logic [34:0] exp;
    A = 32'h7FFFFFFF; B = 32'h1; ALUFun = 6'b000000; Sign = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (Z !== 32'h80000000) begin
      fails++;
      $display("FAIL pre_reset_value: got Z=%h, expected 80000000", Z);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({Z, Zero, Overflow, Negative} !== 35'd0) begin
      fails++;
      $display("FAIL async_reset_assert: got Z=%h ZVN=%b%b%b, expected 0", Z, Zero, Overflow, Negative);
    end
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; ALUFun = 6'b011110; Sign = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({Z, Zero, Overflow, Negative} !== 35'd0) begin
      fails++;
      $display("FAIL reset_held: got Z=%h, expected 0", Z);
    end
    #2 rst_n = 1'b1;
    A = 32'h00000005; B = 32'h00000005; ALUFun = 6'b000001; Sign = 1'b1;
    exp = model(A, B, ALUFun, Sign);
    @(posedge clk); #1;
    tests++;
    if ({Z, Zero, Overflow, Negative} !== exp) begin
      fails++;
      $display("FAIL reset_release_first: got %h/%b%b%b, expected %h/%b",
               Z, Zero, Overflow, Negative, exp[34:3], exp[2:0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; all requirements below are stated for WIDTH=32.
REQ-002 clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 A  input  32  operand A; also the shift amount source (A[4:0]).
REQ-005 B  input  32  operand B; the shifted value for shifts.
REQ-006 ALUFun  input  6  operation select.
REQ-007 Sign  input  1  1 = signed (two's complement), 0 = unsigned interpretation.
REQ-008 Z  output  32  registered result.
REQ-009 Zero  output  1  registered; 1 when the add/sub result equals 0.
REQ-010 Overflow  output  1  registered add/sub overflow flag.
REQ-011 Negative  output  1  registered; add/sub result-negative flag.

Function
REQ-012 Inputs are sampled every rising clk; Z and flags SHALL update exactly 1 cycle later, with no handshake and a new operation every cycle.
REQ-013 ALUFun[5:4]=00 arithmetic: 000000 ADD Z=A+B; 000001 SUB Z=A-B; wrap modulo 2^32.
REQ-014 ALUFun[5:4]=01 logic: 011000 AND; 011110 OR; 010110 XOR; 010001 NOR; 011010 pass A.
REQ-015 ALUFun[5:4]=10 shift by A[4:0]: 100000 SLL Z=B<<A[4:0]; 100001 SRL (zero fill); 100011 SRA (fill with B[31]); A[31:5] ignored.
REQ-016 ALUFun[5:4]=11 compare: Z={31'b0,c}; ALUFun[3:1]: 001 EQ (A==B); 000 NEQ; 010 LT (A<B; signed if Sign=1, unsigned if Sign=0); 110 LEZ (A<=0, signed); 101 LTZ (A<0, signed); 111 GTZ (A>0, signed); ALUFun[0] ignored.
REQ-017 Any undefined ALUFun code (including compare code 100) SHALL give Z=0.
REQ-018 Overflow, Sign=1: set for signed add/sub overflow; Sign=0: set for carry-out on ADD or borrow on SUB.
REQ-019 Negative, Sign=1: result bit 31; Sign=0: borrow on SUB, otherwise 0.
REQ-020 Zero, Overflow and Negative are defined only for arithmetic ops; they SHALL be 0 for all other codes.
REQ-021 LT SHALL be derived from the shared subtractor, with signed overflow correction when Sign=1.

Reset
REQ-022 While rst_n=0, Z, Zero, Overflow and Negative SHALL be 0 immediately, independent of clk.
REQ-023 When rst_n deasserts mid-stream, the first valid result SHALL appear 1 cycle after the first rising clk with rst_n=1.

Structure
REQ-024 A shared package SHALL hold the ALUFun code constants (group codes, logic codes, shift codes and compare codes) and WIDTH.
REQ-025 There is one sub-module, alu_addsub (adder/subtractor producing sum, carry, overflow and zero), used by the arithmetic ops and by EQ/LT.
REQ-026 Operation decode is combinational; there is a single output register stage.

Verification
REQ-027 A=0x0005B10F, B=0x829F81A3, Sign=1: ADD->0x82A532B2 (N=1, V=0); SUB->0x7D662F6C; AND->0x00058103; OR->0x829FB1AF; XOR->0x829A30AC; NOR->0x7D604E50; passA->0x0005B10F.
REQ-028 Same operands: SLL->0xC0D18000; SRL->0x0001053F; SRA->0xFFFF053F.
REQ-029 Same operands: EQ->0; NEQ->1; LT->0; LEZ->0; GTZ->1; code 111001->0; with Sign=0, LT->1.
REQ-030 Overflow: Sign=1, ADD 0x7FFFFFFF+1 -> Z=0x80000000, V=1; Sign=0, ADD 0xFFFFFFFF+1 -> Z=0, V=1, Zero=1.
REQ-031 Drive rst_n low mid-stream -> outputs go to 0 before the next clk edge; release -> the result follows after 1 cycle.
REQ-032 Back-to-back op changes every cycle -> each result appears exactly 1 cycle after its inputs.
